// File: rtl/loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared definitions for the instruction-memory program loader:
//               FSM state encoding, default frame sync byte and frame format
//               constants.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Default frame start byte.
    localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

    // Bytes assembled into each instruction word.
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : loader_timeout
// Description : Inter-byte watchdog for the program loader. Counts cycles
//               while enabled, clears on request, flags expiry once the count
//               reaches TIMEOUT_CYCLES-1. CNT_W must satisfy
//               2^CNT_W > TIMEOUT_CYCLES.
// Ports       : clk     - system clock
//               reset   - asynchronous active-low reset
//               clear   - force the count to zero (priority over enable)
//               enable  - count this cycle
//               expired - count has reached TIMEOUT_CYCLES-1 while enabled
// Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Gated by enable so a stale count can never fire outside a frame.
    assign expired = enable && (r_count == C_LIMIT);

endmodule : loader_timeout
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Program loader. Frames a UART byte stream as
//               sync, word count, big-endian 32-bit words, XOR checksum,
//               writes the words to instruction memory from address 0 and
//               holds the core until a frame completes cleanly.
// Ports       : clk          - system clock
//               reset        - asynchronous active-low reset
//               in_valid     - receiver has a byte
//               in_data      - received byte
//               in_ready     - loader accepts a byte this cycle
//               imem_we      - instruction memory write strobe
//               imem_addr    - word address being written
//               imem_wdata   - word being written
//               cpu_hold     - hold core PC/reset while high
//               load_done    - one-cycle pulse on successful frame end
//               load_err     - sticky error flag, cleared by next sync byte
//               words_loaded - words written in current/last frame
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DFLT,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         CNT_W          = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [1:0] C_LAST_IDX = 2'(BYTES_PER_WORD - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_in_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_word;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;
    logic [ADDR_W:0]   r_words_loaded;
    logic [ADDR_W:0]   r_count_n;
    logic [7:0]        r_checksum;
    logic [1:0]        r_byte_idx;

    logic              w_xfer;
    logic              w_expired;
    logic              w_to_enable;
    logic              w_to_clear;
    logic              w_last_byte;
    logic [ADDR_W:0]   w_words_inc;
    logic [ADDR_W:0]   w_count_n;
    logic              w_in_ready;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_last_byte = (r_byte_idx == C_LAST_IDX);
    assign w_words_inc = r_words_loaded + (ADDR_W+1)'(1);
    // A count byte of zero requests a full memory image.
    assign w_count_n   = (in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                           : (ADDR_W+1)'(in_data);

    assign w_to_enable = (r_state == COUNT) || (r_state == DATA) || (r_state == CHECK);
    // WRITE neither counts nor clears: the gap across the write cycle is
    // charged to the next byte wait.
    assign w_to_clear  = w_xfer || (r_state == IDLE);

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_to_clear),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    // Next-state logic. A byte arriving in the expiry cycle wins over the
    // timeout since it has already been handshaken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_xfer && (in_data == SYNC_BYTE)) w_next = COUNT;
            COUNT: begin
                if (w_xfer)         w_next = DATA;
                else if (w_expired) w_next = ERR;
            end
            DATA: begin
                if (w_xfer) begin
                    if (w_last_byte) w_next = WRITE;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            WRITE: w_next = (w_words_inc == r_count_n) ? CHECK : DATA;
            CHECK: begin
                if (w_xfer)         w_next = (in_data == r_checksum) ? DONE : ERR;
                else if (w_expired) w_next = ERR;
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_in_ready = !((w_next == WRITE) || (w_next == DONE) || (w_next == ERR));

    // State register plus registered outputs, all derived from the next state
    // so each output is valid in the same cycle as the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_in_ready     <= 1'b1;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_word         <= '0;
            r_cpu_hold     <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_err     <= 1'b0;
            r_words_loaded <= '0;
            r_count_n      <= '0;
            r_checksum     <= '0;
            r_byte_idx     <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= w_in_ready;
            r_imem_we   <= (w_next == WRITE);
            r_load_done <= (w_next == DONE);
            if (w_next == DONE) r_cpu_hold <= 1'b0;
            if (w_next == ERR)  r_load_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_xfer && (in_data == SYNC_BYTE)) begin
                        r_cpu_hold     <= 1'b1;
                        r_load_err     <= 1'b0;
                        r_checksum     <= '0;
                        r_words_loaded <= '0;
                        r_imem_addr    <= '0;
                    end
                end
                COUNT: begin
                    if (w_xfer) begin
                        r_count_n  <= w_count_n;
                        r_byte_idx <= '0;
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        // Big-endian: the first byte shifts up to [31:24].
                        r_word     <= {r_word[23:0], in_data};
                        r_checksum <= r_checksum ^ in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    // Address wraps to 0 only after a full 2^ADDR_W image.
                    r_imem_addr    <= r_imem_addr + ADDR_W'(1);
                    r_words_loaded <= w_words_inc;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_word;
    assign cpu_hold     = r_cpu_hold;
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;
    assign words_loaded = r_words_loaded;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Expected memory writes
//               are queued as frames are driven and compared as the loader
//               emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int         ADDR_W  = 8;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 16;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int          n_checks = 0;
    int          n_pass   = 0;
    wr_t         exp_q[$];
    logic [31:0] words[$];

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(imem_addr), 64'(e.addr));
                check("write_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int waits);
        logic acc;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && waits < 50) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        if (!acc) check("byte_accept", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a full frame built from the words queue; flip != 0 corrupts the
    // checksum byte.
    task automatic load_frame(input logic [7:0] nbyte, input int nwords, input logic [7:0] flip);
        int          w;
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] wd;
        cs = 8'd0;
        send_byte(SYNC, w);
        send_byte(nbyte, w);
        for (int i = 0; i < nwords; i++) begin
            wd = words[i];
            exp_q.push_back(wr_t'{addr: 8'(i), data: wd});
            for (int k = 0; k < 4; k++) begin
                b = wd[31-8*k -: 8];
                send_byte(b, w);
                if (k == 0 && i > 0) check("stall_after_write", 64'(w), 64'd1);
                cs = cs ^ b;
            end
        end
        send_byte(cs ^ flip, w);
        check("stall_before_check", 64'(w), 64'd1);
        if (flip == 8'd0) begin
            check("done_pulse", 64'(load_done), 64'd1);
            check("hold_released", 64'(cpu_hold), 64'd0);
            check("no_err", 64'(load_err), 64'd0);
        end else begin
            check("no_done_on_bad", 64'(load_done), 64'd0);
            check("err_on_bad", 64'(load_err), 64'd1);
            check("hold_kept", 64'(cpu_hold), 64'd1);
        end
        check("words_loaded", 64'(words_loaded), 64'(nwords));
        idle(1);
        check("done_cleared", 64'(load_done), 64'd0);
        check("err_sticky", 64'(load_err), (flip == 8'd0) ? 64'd0 : 64'd1);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd1);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b1;

        // Quiet link after reset: core stays held, nothing written.
        idle(10);
        check("quiet_hold", 64'(cpu_hold), 64'd1);
        check("quiet_ready", 64'(in_ready), 64'd1);
        check("quiet_err", 64'(load_err), 64'd0);

        // Two-word frame, good then bad checksum.
        words = '{32'h12345678, 32'h9ABCDEF0};
        load_frame(8'd2, 2, 8'h00);
        load_frame(8'd2, 2, 8'h01);

        // Leading garbage is discarded in IDLE.
        send_byte(8'h00, w);
        send_byte(8'hFF, w);
        send_byte(8'h5A, w);
        words = '{32'hDEADBEEF};
        load_frame(8'd1, 1, 8'h00);

        // Full image: count byte 0 means 256 words.
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back(32'(i));
        load_frame(8'd0, 256, 8'h00);
        check("wrap_addr", 64'(imem_addr), 64'd0);

        // Stall mid-word until the watchdog fires.
        send_byte(SYNC, w);
        send_byte(8'd1, w);
        send_byte(8'h11, w);
        send_byte(8'h22, w);
        k = 0;
        while (load_err !== 1'b1 && k < 40) begin
            idle(1);
            k++;
        end
        check("timeout_err", 64'(load_err), 64'd1);
        check("timeout_cycles", 64'(k), 64'(TIMEOUT));
        check("timeout_hold", 64'(cpu_hold), 64'd1);
        idle(2);
        send_byte(SYNC, w);
        check("sync_clears_err", 64'(load_err), 64'd0);

        // Async reset in the middle of a word.
        send_byte(8'd1, w);
        send_byte(8'h33, w);
        send_byte(8'h44, w);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_wdata", 64'(imem_wdata), 64'd0);
        check("midrst_hold", 64'(cpu_hold), 64'd1);
        check("midrst_words", 64'(words_loaded), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        words = '{32'hCAFEBABE, 32'h01020304};
        load_frame(8'd2, 2, 8'h00);

        idle(5);
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the instruction memory that the core reads.
- Consumes a byte stream from the board UART receiver and frames it as: sync, word count, words, checksum.
- Assembles 32-bit words and writes them into instruction memory at consecutive word addresses from 0.
- Holds the core (`cpu_hold`) until a load completes cleanly.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (matches the 8-bit PC index).
- SYNC_BYTE, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 1000000, max clk cycles between accepted bytes inside a frame.
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, receiver has a byte.
- in_data, input, 8, received byte.
- in_ready, output, 1, loader accepts byte this cycle; a byte transfers when in_valid && in_ready.
- imem_we, output, 1, instruction memory write strobe (one cycle per word).
- imem_addr, output, ADDR_W, word address being written.
- imem_wdata, output, 32, word being written.
- cpu_hold, output, 1, keep core PC/reset held while high.
- load_done, output, 1, one-cycle pulse on successful frame end.
- load_err, output, 1, sticky error flag.
- words_loaded, output, ADDR_W+1, words written in current/last frame.

Behaviour:
- Reset (reset=0, async) values:
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
  - state=IDLE, timeout counter=0, checksum=0.
- All outputs are registered.
- Byte packing is big-endian: the first data byte of a word is imem_wdata[31:24].
- States:
  - IDLE:
    - Bytes other than SYNC_BYTE are accepted and discarded.
    - On SYNC_BYTE → COUNT; set cpu_hold=1, clear load_err, checksum=0, words_loaded=0, imem_addr=0.
  - COUNT:
    - Next byte is the word count N; N=0 means 2^ADDR_W words.
    - Latch N, byte index=0 → DATA.
  - DATA:
    - Shift each byte into the word register and XOR it into checksum.
    - After the 4th byte → WRITE.
  - WRITE (exactly 1 cycle):
    - imem_we=1 with the current imem_addr and the assembled word; in_ready=0.
    - Next cycle: imem_addr += 1 and words_loaded += 1.
    - If words_loaded reaches N → CHECK, else → DATA.
  - CHECK:
    - Next byte compared to checksum.
    - Equal → DONE. Mismatch → ERR.
  - DONE (1 cycle): load_done=1, cpu_hold=0 → IDLE.
  - ERR (1 cycle): load_err=1 (held until next SYNC_BYTE); cpu_hold stays 1 → IDLE.
- in_ready is 1 in every state except WRITE, DONE and ERR.
- Timeout:
  - In COUNT, DATA and CHECK, the counter increments each cycle without a transfer and clears on any transfer.
  - Reaching TIMEOUT_CYCLES-1 → ERR.
  - Counter is held at 0 in IDLE.
- imem_addr wraps naturally only when N=2^ADDR_W: the final write is at address 2^ADDR_W-1; the increment then wraps to 0 and words_loaded=2^ADDR_W.
- SYNC_BYTE inside a frame is ordinary data and is not a resync.
- Reset mid-frame: return to IDLE with cpu_hold=1. Memory contents are not cleared.
- Latency: last byte of a word accepted in cycle t → imem_we high in cycle t+1. CHECK byte accepted in cycle t → load_done in cycle t+1.

Decomposition:
- Shared package (`loader_pkg`) holds:
  - state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR);
  - SYNC_BYTE default;
  - frame-format constants (BYTES_PER_WORD=4).
- One natural sub-module: `loader_timeout`, the inter-byte counter with clear/enable inputs and an expired output.
- FSM, word assembly and checksum stay in `imem_loader`.

Test Plan:
- Reset release with no input → cpu_hold=1, in_ready=1, imem_we never asserts, load_err=0.
- Stream A5,02, 12,34,56,78, 9A,BC,DE,F0, then checksum 00 (XOR of the 8 data bytes) → two writes: addr0=32'h12345678, addr1=32'h9ABCDEF0; load_done pulse; cpu_hold=0; words_loaded=2.
- Same frame with checksum 01 → both writes still occur; load_err=1; cpu_hold stays 1; no load_done.
- Garbage 00,FF,5A before A5,01,DE,AD,BE,EF,checksum → garbage ignored; single write addr0=32'hDEADBEEF.
- A5,01,11,22 then idle TIMEOUT_CYCLES cycles (run with TIMEOUT_CYCLES=16) → ERR, load_err=1, no imem_we; the next A5 clears load_err.
- A5,00 followed by 256 words of value i → writes addr 0..255; last write at addr 255; words_loaded=256; imem_addr wraps to 0.
- Assert reset mid-DATA → all outputs return to reset values immediately; the following full frame loads correctly.
- in_valid held high across WRITE → no byte is lost: the byte is accepted the cycle after WRITE.
